// File: rtl/div_nbit_restore.sv
// ============================================================================
// div_nbit_restore : sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN selects two's-complement operands.  Rev 1.0
// ============================================================================
`default_nettype none

module div_nbit_restore #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_num_x,
  input  logic [DATA_WIDTH-1:0] i_num_y,
  output logic                  o_busy,
  output logic                  o_end,
  output logic [DATA_WIDTH-1:0] o_quo,
  output logic [DATA_WIDTH-1:0] o_rem,
  output logic                  o_err
);

  localparam int               CNT_W     = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic                  pend_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] dvd_q;
  logic [DATA_WIDTH-1:0] dvs_q;
  logic [DATA_WIDTH-1:0] qacc_q;
  logic [DATA_WIDTH-1:0] prem_q;
  logic                  busy_q;
  logic                  end_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] quo_q;
  logic [DATA_WIDTH-1:0] rem_q;
`ifdef DIV_SIGNED_EN
  logic                  negq_q;
  logic                  negr_q;
`endif

  logic [DATA_WIDTH:0]   shifted;
  logic                  qbit;
  logic [DATA_WIDTH-1:0] trial;
  logic [DATA_WIDTH-1:0] prem_d;
  logic [DATA_WIDTH-1:0] qacc_d;
  logic [DATA_WIDTH-1:0] quo_d;
  logic [DATA_WIDTH-1:0] rem_d;
  logic [DATA_WIDTH-1:0] mag_x;
  logic [DATA_WIDTH-1:0] mag_y;

  // The kept remainder is always below the divisor, so it is stored in
  // DATA_WIDTH bits; only the shifted trial value needs the extra bit.
  always_comb begin
    shifted = {prem_q, dvd_q[DATA_WIDTH-1]};
    qbit    = (shifted >= {1'b0, dvs_q});
    trial   = shifted[DATA_WIDTH-1:0] - dvs_q;
    prem_d  = qbit ? trial : shifted[DATA_WIDTH-1:0];
    qacc_d  = {qacc_q[DATA_WIDTH-2:0], qbit};
    quo_d   = qacc_d;
    rem_d   = prem_d;
    mag_x   = i_num_x;
    mag_y   = i_num_y;
`ifdef DIV_SIGNED_EN
    if (negq_q) quo_d = -qacc_d;
    if (negr_q) rem_d = -prem_d;
    if (i_num_x[DATA_WIDTH-1]) mag_x = -i_num_x;
    if (i_num_y[DATA_WIDTH-1]) mag_y = -i_num_y;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      qacc_q  <= '0;
      prem_q  <= '0;
      busy_q  <= 1'b0;
      end_q   <= 1'b0;
      err_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      end_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          // The accept edge only latches operands; CALC starts one edge
          // later so o_end lands DATA_WIDTH+1 edges after the accept.
          if (pend_q) begin
            pend_q  <= 1'b0;
            state_q <= S_CALC;
            busy_q  <= 1'b1;
          end else if (i_start) begin
            if (i_num_y == '0) begin
              state_q <= S_DONE;
              end_q   <= 1'b1;
              quo_q   <= '1;
              rem_q   <= i_num_x;
              err_q   <= 1'b1;
            end else begin
              pend_q  <= 1'b1;
              err_q   <= 1'b0;
              dvd_q   <= mag_x;
              dvs_q   <= mag_y;
              prem_q  <= '0;
              qacc_q  <= '0;
              cnt_q   <= '0;
`ifdef DIV_SIGNED_EN
              negq_q  <= i_num_x[DATA_WIDTH-1] ^ i_num_y[DATA_WIDTH-1];
              negr_q  <= i_num_x[DATA_WIDTH-1];
`endif
            end
          end
        end
        S_CALC: begin
          cnt_q  <= cnt_q + 1'b1;
          dvd_q  <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
          prem_q <= prem_d;
          qacc_q <= qacc_d;
          if (cnt_q == LAST_STEP) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            end_q   <= 1'b1;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_end  = end_q;
  assign o_quo  = quo_q;
  assign o_rem  = rem_q;
  assign o_err  = err_q;

endmodule

`default_nettype wire
